// File: rtl/temp_ctrl_pkg.sv
// temp_ctrl_pkg: shared state/class encodings and default thresholds for the thermal controller.
package temp_ctrl_pkg;
    typedef enum logic [1:0] {NORMAL = 2'b00, VENT = 2'b01, ALARM = 2'b10, BAD = 2'b11} state_t;
    typedef enum logic [1:0] {COOL = 2'b00, MID = 2'b01, WARM = 2'b10, HOT = 2'b11} class_t;
    localparam int DEF_TEMP_W     = 5;
    localparam int DEF_T_VENT_ON  = 20;
    localparam int DEF_T_VENT_OFF = 18;
    localparam int DEF_T_ALARM    = 28;
    localparam int DEF_DEBOUNCE   = 4;
    localparam int CNT_W          = 4;
endpackage

// File: rtl/sample_debouncer.sv
// sample_debouncer: tracks a candidate state and counts consecutive agreeing valid samples,
// pulsing commit on the sample that reaches DEBOUNCE.
module sample_debouncer
    import temp_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   muestra_valid,
    input  logic   clr,
    input  state_t desired,
    input  state_t state,
    output logic   commit,
    output state_t target
);
    state_t candidate;
    logic [CNT_W-1:0] count, cnt_upd;
    logic same, match;
    always_comb begin
        same    = desired == state;
        match   = desired == candidate;
        cnt_upd = same ? '0 : match ? count + 1'b1 : CNT_W'(1);
        target  = (same || match) ? candidate : desired;
        commit  = muestra_valid && !same && cnt_upd == CNT_W'(DEBOUNCE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= NORMAL;
            count     <= '0;
        end else if (clr) begin
            count     <= '0;
        end else if (muestra_valid) begin
            candidate <= target;
            count     <= commit ? '0 : cnt_upd;
        end
    end
endmodule

// File: rtl/temp_fan_alarm_ctrl.sv
// temp_fan_alarm_ctrl: hysteretic, debounced fan/alarm supervisor driving the 7-segment stage.
// Define VENT_IN_ALARM_EN to keep the fan running while in ALARM.
module temp_fan_alarm_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int TEMP_W     = DEF_TEMP_W,
    parameter int T_VENT_ON  = DEF_T_VENT_ON,
    parameter int T_VENT_OFF = DEF_T_VENT_OFF,
    parameter int T_ALARM    = DEF_T_ALARM,
    parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              muestra_valid,
    input  logic [TEMP_W-1:0] temperatura,
    input  logic              ack_alarma,
    output logic              ventilacion,
    output logic              alarma,
    output logic [1:0]        estado
);
    state_t state, state_nx, desired, target;
    class_t cls;
    logic last_hot, hot_nx, ack_exit, commit;
    always_comb begin
        cls = temperatura >= TEMP_W'(T_ALARM)    ? HOT  :
              temperatura >= TEMP_W'(T_VENT_ON)  ? WARM :
              temperatura <= TEMP_W'(T_VENT_OFF) ? COOL : MID;
        hot_nx  = muestra_valid ? cls == HOT : last_hot;
        desired = state == ALARM ? ALARM :
                  state == BAD   ? NORMAL :
                  cls == HOT     ? ALARM :
                  state == NORMAL ? (cls == WARM ? VENT : NORMAL) :
                  (cls == COOL ? NORMAL : VENT);
        // ack sees the classification of a same-cycle sample
        ack_exit = state == ALARM && ack_alarma && !hot_nx;
        state_nx = state == BAD ? NORMAL : ack_exit ? VENT : commit ? target : state;
    end
    sample_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk          (clk),
        .rst_n        (rst_n),
        .muestra_valid(muestra_valid),
        .clr          (ack_exit || state == BAD),
        .desired      (desired),
        .state        (state),
        .commit       (commit),
        .target       (target)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NORMAL;
            last_hot    <= 1'b0;
            ventilacion <= 1'b0;
            alarma      <= 1'b0;
        end else begin
            state       <= state_nx;
            last_hot    <= hot_nx;
            alarma      <= state_nx == ALARM;
`ifdef VENT_IN_ALARM_EN
            ventilacion <= state_nx == VENT || state_nx == ALARM;
`else
            ventilacion <= state_nx == VENT;
`endif
        end
    end
    assign estado = state;
endmodule
